// File: rtl/led_fader_pkg.sv
// Shared types and helpers for the led_fader block.
package led_fader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_COMMIT_WAIT
    } scan_state_t;

    localparam string GAMMA_FILE = "gamma16.list";

    function automatic logic [31:0] level_max(input int bits);
        return (bits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    endfunction

    // Replicates the level MSB-first across the duty width, so full scale maps to near-full duty.
    function automatic logic [31:0] expand_level(input logic [31:0] level,
                                                 input int level_bits,
                                                 input int pwm_bits);
        logic [31:0] r;
        int          src;
        r = '0;
        for (int j = 0; j < 32; j++) begin
            if (j < pwm_bits) begin
                src  = level_bits - 1 - ((pwm_bits - 1 - j) % level_bits);
                r[j] = level[src[4:0]];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_fader_gamma_lut.sv
// gamma_lut: synchronous gamma ROM with one registered read port.
// Only compiled when LED_FADER_GAMMA_EN is defined.
`ifdef LED_FADER_GAMMA_EN
module gamma_lut #(
  parameter int    ADDR_W    = 8,
  parameter int    DATA_W    = 16,
  parameter string INIT_FILE = "gamma16.list"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] rom [DEPTH];

  function automatic logic [DATA_W-1:0] gamma_entry(input int unsigned lvl);
    logic [127:0] lmax;
    logic [127:0] dmax;
    logic [127:0] num;
    lmax = 128'(DEPTH - 1);
    dmax = (128'd1 << DATA_W) - 128'd1;
    if (lmax == 0) begin
      return DATA_W'(dmax);
    end
    num = 128'(lvl) * 128'(lvl) * dmax;
    return DATA_W'((num + (lmax * lmax) / 2) / (lmax * lmax));
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      rom[i] = gamma_entry(i);
    end
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule
`endif

// File: rtl/led_fader.sv
// led_fader: multi-channel PWM LED fader with per-channel ramping and period-aligned duty commit.
// Define LED_FADER_GAMMA_EN to map levels through gamma_lut instead of bit replication.
module led_fader #(
    parameter int NUM_CH     = 3,
    parameter int LEVEL_BITS = 8,
    parameter int PWM_BITS   = 16,
    parameter int STEP_DIV   = 4096,
    parameter int INVERT     = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cmd_ch,
    input  logic [LEVEL_BITS-1:0]                   cmd_level,
    input  logic                                    cmd_imm,
    output logic                                    busy,
    output logic [NUM_CH-1:0]                       led
);
    import led_fader_pkg::*;

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W  = $clog2(NUM_CH + 1);
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [LEVEL_BITS-1:0] LEVEL_MAX = LEVEL_BITS'(level_max(LEVEL_BITS));
    localparam logic INV = (INVERT != 0);

    logic [LEVEL_BITS-1:0] tgt [NUM_CH];
    logic [LEVEL_BITS-1:0] cur [NUM_CH];
    logic [PWM_BITS-1:0]   duty_shadow [NUM_CH];
    logic [PWM_BITS-1:0]   duty_active [NUM_CH];
    logic [NUM_CH-1:0]     full_shadow;
    logic [NUM_CH-1:0]     full_active;

    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [STEP_W-1:0]     step_cnt;
    logic                  tick;
    logic                  accept;

    scan_state_t           state;
    logic [IDX_W-1:0]      idx;

    logic [LEVEL_BITS-1:0] scan_level_p0;
    logic [PWM_BITS-1:0]   duty_p1;
    logic                  full_p1;

    logic                  any_diff;
    logic [NUM_CH-1:0]     led_next;

    assign tick   = (step_cnt == STEP_W'(STEP_DIV - 1));
    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            pwm_cnt   <= '0;
            step_cnt  <= '0;
            led       <= {NUM_CH{INV}};
        end else begin
            cmd_ready <= 1'b1;
            busy      <= any_diff;
            pwm_cnt   <= pwm_cnt + 1'b1;
            step_cnt  <= tick ? '0 : step_cnt + 1'b1;
            led       <= led_next;
        end
    end

    // Tick moves cur toward the old target; a command to the same channel then overrides what it writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                tgt[i] <= '0;
                cur[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (tick) begin
                    if (cur[i] < tgt[i]) begin
                        cur[i] <= cur[i] + 1'b1;
                    end else if (cur[i] > tgt[i]) begin
                        cur[i] <= cur[i] - 1'b1;
                    end
                end
                if (accept && (cmd_ch == CH_W'(i))) begin
                    tgt[i] <= cmd_level;
                    if (cmd_imm) begin
                        cur[i] <= cmd_level;
                    end
                end
            end
        end
    end

    always_comb begin
        any_diff = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur[i] != tgt[i]) begin
                any_diff = 1'b1;
            end
        end
    end

    // Stage p0: select the level being read this scan slot.
    always_comb begin
        scan_level_p0 = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (idx == IDX_W'(i)) begin
                scan_level_p0 = cur[i];
            end
        end
    end

    // Stage p1: registered duty lookup, one cycle behind the issue.
`ifdef LED_FADER_GAMMA_EN
    gamma_lut #(
        .ADDR_W    (LEVEL_BITS),
        .DATA_W    (PWM_BITS),
        .INIT_FILE (GAMMA_FILE)
    ) u_gamma_lut (
        .clk  (clk),
        .addr (scan_level_p0),
        .data (duty_p1)
    );
`else
    always_ff @(posedge clk) begin
        duty_p1 <= PWM_BITS'(expand_level(32'(scan_level_p0), LEVEL_BITS, PWM_BITS));
    end
`endif

    always_ff @(posedge clk) begin
        full_p1 <= (scan_level_p0 == LEVEL_MAX);
    end

    // Scan runs NUM_CH issue slots plus one capture slot; commit waits for the wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            full_shadow <= '0;
            full_active <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_shadow[i] <= '0;
                duty_active[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pwm_cnt == '0) begin
                        state <= ST_SCAN;
                        idx   <= '0;
                    end
                end
                ST_SCAN: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx == IDX_W'(i + 1)) begin
                            duty_shadow[i] <= duty_p1;
                            full_shadow[i] <= full_p1;
                        end
                    end
                    if (idx == IDX_W'(NUM_CH)) begin
                        state <= ST_COMMIT_WAIT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_COMMIT_WAIT: begin
                    if (pwm_cnt == '1) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            duty_active[i] <= duty_shadow[i];
                        end
                        full_active <= full_shadow;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        led_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            led_next[i] = (full_active[i] | (pwm_cnt < duty_active[i])) ^ INV;
        end
    end

endmodule
